// File: rtl/halfword_narrower_if.sv
// rtl/halfword_narrower_if.sv - handshake and counter bundle for halfword_narrower
//
// Purpose: groups the word input stream, the halfword output stream and the
// overflow counter signals of halfword_narrower into one bundle.
// Signals:
//   in_valid/in_ready/in_data/in_unsigned/in_saturate  32-bit word input stream
//   out_valid/out_ready/out_data/out_overflow          16-bit result stream
//   clr_count/ovf_count                                 overflow counter clear/value
// Modports: slave = the narrower itself, master = its producer/consumer.
interface halfword_narrower_if #(
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_unsigned;
    logic             in_saturate;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             out_overflow;
    logic             clr_count;
    logic [CNT_W-1:0] ovf_count;

    modport slave (
        input  in_valid, in_data, in_unsigned, in_saturate, out_ready, clr_count,
        output in_ready, out_valid, out_data, out_overflow, ovf_count
    );

    modport master (
        output in_valid, in_data, in_unsigned, in_saturate, out_ready, clr_count,
        input  in_ready, out_valid, out_data, out_overflow, ovf_count
    );
endinterface

// File: rtl/halfword_narrower.sv
// rtl/halfword_narrower.sv - 32-to-16 bit narrowing with saturation and 2-entry output buffer
//
// Purpose: range-checks each 32-bit word against signed or unsigned 16-bit
// limits, truncates or saturates it, and queues the result with its overflow
// flag in a 2-entry FIFO. A saturating counter tracks delivered overflows.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    halfword_narrower_if.slave (input stream, output stream, counter)
module halfword_narrower #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                rst_n,
    halfword_narrower_if.slave bus
);
    localparam logic [1:0] FULL_COUNT = 2'(DEPTH);

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0][15:0] data_q, data_d;
    logic [1:0]       ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        in_ready_w;
    logic        out_valid_w;
    logic        push;
    logic        pop;
    logic        ovf_unsigned;
    logic        ovf_signed;
    logic        ovf_w;
    logic [15:0] sat_val;
    logic [15:0] result_w;

    // Ready is a pure decode of the registered occupancy, so there is no
    // combinational path from out_ready back to in_ready.
    assign in_ready_w  = (count_q != FULL_COUNT);
    assign out_valid_w = (count_q != 2'd0);
    assign push        = bus.in_valid && in_ready_w;
    assign pop         = out_valid_w && bus.out_ready;

    // Signed fit requires bits 31..15 to be copies of one sign bit.
    assign ovf_unsigned = |bus.in_data[31:16];
    assign ovf_signed   = !((&bus.in_data[31:15]) || !(|bus.in_data[31:15]));
    assign ovf_w        = bus.in_unsigned ? ovf_unsigned : ovf_signed;
    assign sat_val      = bus.in_unsigned ? 16'hFFFF
                        : (bus.in_data[31] ? 16'h8000 : 16'h7FFF);
    assign result_w     = (ovf_w && bus.in_saturate) ? sat_val : bus.in_data[15:0];

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;

        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end

        if (push) begin
            data_d[wr_ptr_q] = result_w;
            ovf_d[wr_ptr_q]  = ovf_w;
            wr_ptr_d         = !wr_ptr_q;
        end

        if (pop) begin
            rd_ptr_d = !rd_ptr_q;
        end

        // Clear has priority over a counting pop in the same cycle.
        if (bus.clr_count) begin
            cnt_d = '0;
        end else if (pop && ovf_q[rd_ptr_q] && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            data_q   <= '0;
            ovf_q    <= '0;
            cnt_q    <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
        end
    end

    // Head fields are forced to zero while the buffer is empty.
    assign bus.in_ready     = in_ready_w;
    assign bus.out_valid    = out_valid_w;
    assign bus.out_data     = out_valid_w ? data_q[rd_ptr_q] : 16'h0000;
    assign bus.out_overflow = out_valid_w && ovf_q[rd_ptr_q];
    assign bus.ovf_count    = cnt_q;
endmodule

// File: doc/halfword_narrower.md
# halfword_narrower

Narrows 32-bit datapath values to 16-bit halfwords. It is the inverse of the immediate sign/zero extension path and is used on the halfword store and export side of the single-cycle processor. Each word is range-checked against signed or unsigned 16-bit limits, then truncated or saturated. Results pass through a 2-entry valid/ready buffer, and a saturating counter records how many delivered results overflowed.

## Interface
- DEPTH, 2: buffer entries; fixed at 2, not to be overridden.
- CNT_W, 8: width of the overflow counter.

Ports:
- clk  input  1  rising-edge clock; the single clock domain.
- rst_n  input  1  asynchronous reset, active-low.
- in_valid  input  1  producer offers a word.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  32  word to narrow.
- in_unsigned  input  1  1 = treat in_data as unsigned 32-bit; 0 = signed two's complement.
- in_saturate  input  1  1 = clamp on overflow; 0 = truncate to in_data[15:0].
- out_valid  output  1  buffer head holds a result.
- out_ready  input  1  consumer takes the head this cycle.
- out_data  output  16  narrowed result at the buffer head.
- out_overflow  output  1  head result did not fit in 16 bits.
- clr_count  input  1  synchronous clear of ovf_count.
- ovf_count  output  CNT_W  count of delivered results with overflow; saturates at all-ones.

## Operation
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- Narrowing and the overflow check are combinational on in_data. Results are registered into the buffer on push.
- Overflow, unsigned: in_data[31:16] != 0.
- Overflow, signed: in_data[31:15] is not all-equal.
- No overflow: result = in_data[15:0].
- Overflow with in_saturate=0: result = in_data[15:0].
- Overflow with in_saturate=1:
  - unsigned → 0xFFFF
  - signed with in_data[31]=0 → 0x7FFF
  - signed with in_data[31]=1 → 0x8000
- The overflow flag is stored per entry regardless of in_saturate.
- The buffer is a FIFO with an occupancy count of 0..2, in order, no reordering.
- in_ready = (count < 2). It depends only on registered state, with no combinational path from out_ready.
- Push while full: impossible, because in_ready=0.
- Simultaneous push and pop with count 1: count stays 1. The new entry becomes the head on the next cycle.
- Pop while empty: impossible, because out_valid=0.
- ovf_count increments by 1 on a pop whose head has out_overflow=1. It holds at 2^CNT_W-1.
- clr_count=1 forces ovf_count to 0 on the next edge. If a counting pop occurs in the same cycle, the clear wins and the result is 0.
- When out_valid=0, out_data and out_overflow are 0.

## Timing
- Reset (rst_n low, asynchronous):
  - count=0, so out_valid=0 and in_ready=1
  - out_data=0x0000, out_overflow=0, ovf_count=0
  - buffer contents cleared
- Reset asserted mid-transfer discards all buffered entries. No partial pop is counted.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N, i.e. during cycle N+1. There is no same-cycle bypass.
- Throughput: 1 word/cycle sustained when out_ready is held high.
- With out_ready low, 2 words are accepted, then in_ready drops in the cycle after the 2nd push.
- After a pop from full, in_ready returns to 1 in the following cycle.
- Outputs (out_valid, out_data, out_overflow, in_ready, ovf_count) are driven from registers or count decode only.

## Test plan
- Reset and basic pass, signed: after reset check in_ready=1, out_valid=0, ovf_count=0. Push 0xFFFF_8000 (signed, sat=1) → next cycle out_data=0x8000, out_overflow=0.
- Signed saturation: push 0x0001_0000 with sat=1 → 0x7FFF, ovf=1. Push 0xFFFE_FFFF with sat=1 → 0x8000, ovf=1. Same two words with sat=0 → 0x0000 and 0xFFFF, ovf=1.
- Unsigned boundaries: 0x0000_FFFF → 0xFFFF, ovf=0. 0x0001_0000 with sat=1 → 0xFFFF, ovf=1. 0x8000_0000 with sat=0 → 0x0000, ovf=1.
- Backpressure: hold out_ready=0 and push A, B → in_ready=0 after 2nd push. Raise out_ready → A then B pop in order, in_ready=1 one cycle after the first pop. Then stream 10 words with out_ready=1 → 1/cycle, in order.
- Counter: deliver 300 overflowing results → ovf_count saturates at 255. Assert clr_count on the same cycle as an overflowing pop → ovf_count=0.
- Async reset mid-operation: with 2 entries buffered, pulse rst_n low between clock edges → outputs reset immediately. After release, no stale entry appears and ovf_count=0.
